// File: rtl/dpram_pkg.sv
// Shared types and helpers for the true-dual-port RAM.
package dpram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } dpram_state_e;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;

    function automatic int nb(input int dw, input int bw);
        return dw / bw;
    endfunction

endpackage

// File: rtl/dpram_out_pipe.sv
// Per-port output stage: holds read data between requests, optionally adds one register.
module dpram_out_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o
);

    logic [DATA_WIDTH-1:0] hold_reg;

    generate
        if (OUT_REG == 0) begin : g_direct
            // Fresh RAM data passes straight through; the last delivered word is held otherwise.
            assign data_o  = valid_i ? data_i : hold_reg;
            assign valid_o = valid_i;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    hold_reg <= '0;
                end else if (valid_i) begin
                    hold_reg <= data_i;
                end
            end
        end else begin : g_registered
            logic valid_reg;

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    hold_reg  <= '0;
                    valid_reg <= 1'b0;
                end else begin
                    valid_reg <= valid_i;
                    if (valid_i) begin
                        hold_reg <= data_i;
                    end
                end
            end

            assign data_o  = hold_reg;
            assign valid_o = valid_reg;
        end
    endgenerate

endmodule

// File: rtl/dpram_tdp.sv
// Single-clock true-dual-port RAM with byte lanes, selectable read-during-write
// behaviour, optional output register and a hardware clear sweep after reset.
module dpram_tdp
    import dpram_pkg::*;
#(
    parameter int                   DATA_WIDTH     = 8,
    parameter int                   ADDR_WIDTH     = 10,
    parameter int                   BYTE_WIDTH     = 8,
    parameter int                   RDW_MODE       = 0,
    parameter int                   OUT_REG        = 0,
    parameter int                   CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0,
    localparam int                  NB             = nb(DATA_WIDTH, BYTE_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    output logic                  ready_o,
    input  logic                  en_a_i,
    input  logic                  we_a_i,
    input  logic [NB-1:0]         be_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic                  valid_a_o,
    input  logic                  en_b_i,
    input  logic                  we_b_i,
    input  logic [NB-1:0]         be_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic                  valid_b_o,
    output logic                  collision_o
);

    localparam int                  DEPTH       = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam bit                  WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
            $error("dpram_tdp: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
    endgenerate

    dpram_state_e          state_reg;
    logic [ADDR_WIDTH-1:0] cnt_reg;
    logic                  ready_reg;
    logic                  collision_reg;
    logic                  valid_a_reg;
    logic                  valid_b_reg;

    logic                  clearing;
    logic                  acc_a;
    logic                  acc_b;
    logic [ADDR_WIDTH-1:0] wr_addr_a;
    logic [DATA_WIDTH-1:0] wr_data_a;
    logic [NB-1:0]         wr_lane_a;
    logic [NB-1:0]         wr_lane_b;
    logic [DATA_WIDTH-1:0] rd_a_word;
    logic [DATA_WIDTH-1:0] rd_b_word;

    assign clearing = (state_reg == S_CLEAR);
    assign acc_a    = !clearing && en_a_i;
    assign acc_b    = !clearing && en_b_i;

    // The clear sweep borrows port A's write path.
    assign wr_addr_a = clearing ? cnt_reg : addr_a_i;
    assign wr_data_a = clearing ? CLEAR_VALUE : data_a_i;
    assign wr_lane_a = clearing ? {NB{1'b1}} : ((acc_a && we_a_i) ? be_a_i : {NB{1'b0}});
    assign wr_lane_b = (acc_b && we_b_i) ? be_b_i : {NB{1'b0}};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
            cnt_reg       <= '0;
            ready_reg     <= 1'b0;
            collision_reg <= 1'b0;
            valid_a_reg   <= 1'b0;
            valid_b_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg <= S_RUN;
                        ready_reg <= 1'b1;
                    end
                end
                S_RUN:   ready_reg <= 1'b1;
                default: state_reg <= S_RUN;
            endcase
            valid_a_reg   <= acc_a;
            valid_b_reg   <= acc_b;
            collision_reg <= acc_a && acc_b && we_a_i && we_b_i &&
                             (addr_a_i == addr_b_i) && (|(be_a_i & be_b_i));
        end
    end

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] mem [DEPTH];
            logic [BYTE_WIDTH-1:0] din_a;
            logic [BYTE_WIDTH-1:0] din_b;
            logic [BYTE_WIDTH-1:0] rd_a_reg;
            logic [BYTE_WIDTH-1:0] rd_b_reg;

            assign din_a = wr_data_a[gi*BYTE_WIDTH +: BYTE_WIDTH];
            assign din_b = data_b_i[gi*BYTE_WIDTH +: BYTE_WIDTH];

            // Port A is written last so it wins lanes both ports enable on one address.
            always_ff @(posedge clk_i) begin
                if (wr_lane_b[gi]) begin
                    mem[addr_b_i] <= din_b;
                end
                if (wr_lane_a[gi]) begin
                    mem[wr_addr_a] <= din_a;
                end
            end

            // The array read returns the pre-write word, so the other port always sees old data.
            always_ff @(posedge clk_i) begin
                if (WRITE_FIRST && wr_lane_a[gi]) begin
                    rd_a_reg <= din_a;
                end else begin
                    rd_a_reg <= mem[addr_a_i];
                end
                if (WRITE_FIRST && wr_lane_b[gi]) begin
                    rd_b_reg <= din_b;
                end else begin
                    rd_b_reg <= mem[addr_b_i];
                end
            end

            assign rd_a_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_a_reg;
            assign rd_b_word[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_b_reg;
        end
    endgenerate

    dpram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_a (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (rd_a_word),
        .valid_i (valid_a_reg),
        .data_o  (data_a_o),
        .valid_o (valid_a_o)
    );

    dpram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUT_REG    (OUT_REG)
    ) u_pipe_b (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (rd_b_word),
        .valid_i (valid_b_reg),
        .data_o  (data_b_o),
        .valid_o (valid_b_o)
    );

    assign ready_o     = ready_reg;
    assign collision_o = collision_reg;

endmodule
